// File: rtl/nco_mc_tdm.sv
// nco_mc_tdm: time-multiplexed multi-channel numerically controlled oscillator.
// One phase accumulator datapath and one quarter-wave sine table serve nc
// channels in round-robin order. Each channel has its own phase increment,
// phase offset and pending phase-clear flag.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clken          advances the channel counter, accumulators and pipeline
//   cfg_we         config write strobe (acts regardless of clken)
//   cfg_sel        0 = phase increment, 1 = phase offset
//   cfg_ch         channel targeted by the config write
//   cfg_data       config write data
//   phase_clr      per-channel clear request pulses
//   fsin_o/fcos_o  signed sine/cosine of the current output sample
//   out_ch         channel index of the current output sample
//   out_sop        high when out_ch is channel 0
//   out_valid      pipeline has filled since reset
module nco_mc_tdm #(
    parameter int apr    = 32,
    parameter int mpr    = 14,
    parameter int raw    = 10,
    parameter int nc     = 4,
    parameter int log2nc = 2,
    parameter     rf     = "nco_sin_q.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [log2nc-1:0] cfg_ch,
    input  logic [apr-1:0]    cfg_data,
    input  logic [nc-1:0]     phase_clr,
    output logic [mpr-1:0]    fsin_o,
    output logic [mpr-1:0]    fcos_o,
    output logic [log2nc-1:0] out_ch,
    output logic              out_sop,
    output logic              out_valid
);

    localparam logic [mpr-2:0] PEAK = '1;

    // Table word k = round(PEAK * sin(pi*k / 2^(raw+1))), evaluated at
    // elaboration with a Taylor series so the table needs no external file;
    // the contents are those the rf table file carries.
    function automatic logic [mpr-2:0] rom_word(input int unsigned k);
        real x;
        real term;
        real s;
        int  v;
        x    = 3.14159265358979323846 * real'(k) / real'(2 ** (raw + 1));
        s    = 0.0;
        term = x;
        for (int unsigned n = 1; n <= 12; n++) begin
            s    = s + term;
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
        end
        v = $rtoi(s * real'(2 ** (mpr - 1) - 1) + 0.5);
        return v[mpr-2:0];
    endfunction

    logic [mpr-2:0] rom [2**raw];

    for (genvar k = 0; k < 2 ** raw; k++) begin : g_rom
        localparam logic [mpr-2:0] WORD = rom_word(k);
        assign rom[k] = WORD;
    end

    // Per-channel state
    logic [apr-1:0]    acc_q [nc];
    logic [apr-1:0]    acc_d [nc];
    logic [apr-1:0]    inc_q [nc];
    logic [apr-1:0]    inc_d [nc];
    logic [apr-1:0]    off_q [nc];
    logic [apr-1:0]    off_d [nc];
    logic [nc-1:0]     clr_pend_q, clr_pend_d;
    logic [log2nc-1:0] ch_cnt_q, ch_cnt_d;

    // Pipeline: S1 keeps only the phase bits that address the table
    logic [raw+1:0]    s1_p_q, s1_p_d;
    logic [log2nc-1:0] s1_ch_q, s1_ch_d;
    logic [raw-1:0]    s2_sin_addr_q, s2_sin_addr_d, s2_cos_addr_q, s2_cos_addr_d;
    logic              s2_sin_pk_q, s2_sin_pk_d, s2_cos_pk_q, s2_cos_pk_d;
    logic              s2_sin_neg_q, s2_sin_neg_d, s2_cos_neg_q, s2_cos_neg_d;
    logic [log2nc-1:0] s2_ch_q, s2_ch_d;
    logic [mpr-2:0]    s3_sin_mag_q, s3_sin_mag_d, s3_cos_mag_q, s3_cos_mag_d;
    logic              s3_sin_neg_q, s3_sin_neg_d, s3_cos_neg_q, s3_cos_neg_d;
    logic [log2nc-1:0] s3_ch_q, s3_ch_d;
    logic [mpr-1:0]    fsin_q, fsin_d, fcos_q, fcos_d;
    logic [log2nc-1:0] out_ch_q, out_ch_d;
    logic              out_sop_q, out_sop_d;
    logic [1:0]        fill_q, fill_d;
    logic              out_valid_q, out_valid_d;

    // Visit-cycle values and S2 helpers
    logic [apr-1:0]    vis_acc, vis_inc, vis_off;
    logic              vis_clr;
    logic [1:0]        q_sin, q_cos;
    logic [raw-1:0]    a_idx;

    always_comb begin
        acc_d         = acc_q;
        inc_d         = inc_q;
        off_d         = off_q;
        clr_pend_d    = clr_pend_q;
        ch_cnt_d      = ch_cnt_q;
        s1_p_d        = s1_p_q;
        s1_ch_d       = s1_ch_q;
        s2_sin_addr_d = s2_sin_addr_q;
        s2_cos_addr_d = s2_cos_addr_q;
        s2_sin_pk_d   = s2_sin_pk_q;
        s2_cos_pk_d   = s2_cos_pk_q;
        s2_sin_neg_d  = s2_sin_neg_q;
        s2_cos_neg_d  = s2_cos_neg_q;
        s2_ch_d       = s2_ch_q;
        s3_sin_mag_d  = s3_sin_mag_q;
        s3_cos_mag_d  = s3_cos_mag_q;
        s3_sin_neg_d  = s3_sin_neg_q;
        s3_cos_neg_d  = s3_cos_neg_q;
        s3_ch_d       = s3_ch_q;
        fsin_d        = fsin_q;
        fcos_d        = fcos_q;
        out_ch_d      = out_ch_q;
        out_sop_d     = out_sop_q;
        fill_d        = fill_q;
        out_valid_d   = out_valid_q;

        vis_acc = acc_q[ch_cnt_q];
        vis_inc = inc_q[ch_cnt_q];
        vis_off = off_q[ch_cnt_q];
        vis_clr = clr_pend_q[ch_cnt_q];

        q_sin = s1_p_q[raw+1:raw];
        q_cos = q_sin + 2'd1;
        a_idx = s1_p_q[raw-1:0];

        if (clken) begin
            // Visit: a pending clear restarts the channel at its offset
            acc_d[ch_cnt_q] = vis_clr ? vis_inc : vis_acc + vis_inc;
            ch_cnt_d = (ch_cnt_q == log2nc'(nc - 1)) ? '0 : ch_cnt_q + log2nc'(1);
            s1_p_d   = (raw+2)'((vis_clr ? vis_off : vis_acc + vis_off) >> (apr - raw - 2));
            s1_ch_d  = ch_cnt_q;

            // Odd quadrants mirror the table; a = 0 there is the peak,
            // one past the last stored word
            s2_sin_addr_d = q_sin[0] ? -a_idx : a_idx;
            s2_cos_addr_d = q_cos[0] ? -a_idx : a_idx;
            s2_sin_pk_d   = q_sin[0] && (a_idx == '0);
            s2_cos_pk_d   = q_cos[0] && (a_idx == '0);
            s2_sin_neg_d  = q_sin[1];
            s2_cos_neg_d  = q_cos[1];
            s2_ch_d       = s1_ch_q;

            s3_sin_mag_d = s2_sin_pk_q ? PEAK : rom[s2_sin_addr_q];
            s3_cos_mag_d = s2_cos_pk_q ? PEAK : rom[s2_cos_addr_q];
            s3_sin_neg_d = s2_sin_neg_q;
            s3_cos_neg_d = s2_cos_neg_q;
            s3_ch_d      = s2_ch_q;

            fsin_d    = s3_sin_neg_q ? -{1'b0, s3_sin_mag_q} : {1'b0, s3_sin_mag_q};
            fcos_d    = s3_cos_neg_q ? -{1'b0, s3_cos_mag_q} : {1'b0, s3_cos_mag_q};
            out_ch_d  = s3_ch_q;
            out_sop_d = (s3_ch_q == '0);

            if (!out_valid_q) begin
                if (fill_q == 2'd3) out_valid_d = 1'b1;
                else                fill_d      = fill_q + 2'd1;
            end
        end

        // A fresh request in the consume cycle stays pending
        for (int unsigned i = 0; i < nc; i++) begin
            clr_pend_d[i] = (clr_pend_q[i]
                             & ~(clken && (ch_cnt_q == log2nc'(i))))
                            | phase_clr[i];
        end

        if (cfg_we) begin
            for (int unsigned i = 0; i < nc; i++) begin
                if (cfg_ch == log2nc'(i)) begin
                    if (cfg_sel) off_d[i] = cfg_data;
                    else         inc_d[i] = cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < nc; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
                off_q[i] <= '0;
            end
            clr_pend_q    <= '0;
            ch_cnt_q      <= '0;
            s1_p_q        <= '0;
            s1_ch_q       <= '0;
            s2_sin_addr_q <= '0;
            s2_cos_addr_q <= '0;
            s2_sin_pk_q   <= 1'b0;
            s2_cos_pk_q   <= 1'b0;
            s2_sin_neg_q  <= 1'b0;
            s2_cos_neg_q  <= 1'b0;
            s2_ch_q       <= '0;
            s3_sin_mag_q  <= '0;
            s3_cos_mag_q  <= '0;
            s3_sin_neg_q  <= 1'b0;
            s3_cos_neg_q  <= 1'b0;
            s3_ch_q       <= '0;
            fsin_q        <= '0;
            fcos_q        <= '0;
            out_ch_q      <= '0;
            out_sop_q     <= 1'b0;
            fill_q        <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            inc_q         <= inc_d;
            off_q         <= off_d;
            clr_pend_q    <= clr_pend_d;
            ch_cnt_q      <= ch_cnt_d;
            s1_p_q        <= s1_p_d;
            s1_ch_q       <= s1_ch_d;
            s2_sin_addr_q <= s2_sin_addr_d;
            s2_cos_addr_q <= s2_cos_addr_d;
            s2_sin_pk_q   <= s2_sin_pk_d;
            s2_cos_pk_q   <= s2_cos_pk_d;
            s2_sin_neg_q  <= s2_sin_neg_d;
            s2_cos_neg_q  <= s2_cos_neg_d;
            s2_ch_q       <= s2_ch_d;
            s3_sin_mag_q  <= s3_sin_mag_d;
            s3_cos_mag_q  <= s3_cos_mag_d;
            s3_sin_neg_q  <= s3_sin_neg_d;
            s3_cos_neg_q  <= s3_cos_neg_d;
            s3_ch_q       <= s3_ch_d;
            fsin_q        <= fsin_d;
            fcos_q        <= fcos_d;
            out_ch_q      <= out_ch_d;
            out_sop_q     <= out_sop_d;
            fill_q        <= fill_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign fsin_o    = fsin_q;
    assign fcos_o    = fcos_q;
    assign out_ch    = out_ch_q;
    assign out_sop   = out_sop_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nco_mc_tdm.sv
// tb_nco_mc_tdm: scoreboard bench for nco_mc_tdm. A reference model advanced
// alongside the stimulus predicts each channel visit's sine/cosine from the
// ideal trigonometric value at the quantised phase and queues it; a monitor
// compares every new output sample, held outputs and reset behaviour.
module tb_nco_mc_tdm;

    localparam int APR = 32;
    localparam int MPR = 14;
    localparam int RAW = 10;
    localparam int NC  = 4;
    localparam int L2  = 2;
    localparam real PI = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              reset;
    logic              clken;
    logic              cfg_we;
    logic              cfg_sel;
    logic [L2-1:0]     cfg_ch;
    logic [APR-1:0]    cfg_data;
    logic [NC-1:0]     phase_clr;
    logic [MPR-1:0]    fsin_o;
    logic [MPR-1:0]    fcos_o;
    logic [L2-1:0]     out_ch;
    logic              out_sop;
    logic              out_valid;

    nco_mc_tdm #(
        .apr(APR), .mpr(MPR), .raw(RAW), .nc(NC), .log2nc(L2)
    ) dut (
        .clk(clk), .reset(reset), .clken(clken), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .phase_clr(phase_clr), .fsin_o(fsin_o), .fcos_o(fcos_o),
        .out_ch(out_ch), .out_sop(out_sop), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int c;
        int ch;
    } exp_t;

    exp_t           exp_q[$];
    logic [APR-1:0] m_acc [NC];
    logic [APR-1:0] m_inc [NC];
    logic [APR-1:0] m_off [NC];
    bit             m_clr [NC];
    int             m_ch;
    int             m_fill;
    bit             exp_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Ideal value: sine/cosine of the angle given by the top RAW+2 phase
    // bits, scaled to the peak and rounded half away from zero.
    function automatic int ideal(input logic [APR-1:0] p, input bit want_cos);
        int  n;
        real ang;
        real v;
        n   = int'(p >> (APR - RAW - 2));
        ang = 2.0 * PI * real'(n) / real'(1 << (RAW + 2));
        v   = real'((1 << (MPR - 1)) - 1) * (want_cos ? $cos(ang) : $sin(ang));
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int             c;
        bit             consumed;
        logic [APR-1:0] p;
        exp_t           e;
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                m_acc[i] = '0; m_inc[i] = '0; m_off[i] = '0; m_clr[i] = 1'b0;
            end
            m_ch = 0; m_fill = 0; exp_valid = 1'b0;
            exp_q.delete();
            return;
        end
        consumed = 1'b0;
        c = m_ch;
        if (clken) begin
            p    = m_clr[c] ? m_off[c] : m_acc[c] + m_off[c];
            e.s  = ideal(p, 1'b0);
            e.c  = ideal(p, 1'b1);
            e.ch = c;
            exp_q.push_back(e);
            m_acc[c] = m_clr[c] ? m_inc[c] : m_acc[c] + m_inc[c];
            consumed = m_clr[c];
            m_ch = (c + 1) % NC;
            if (m_fill < 4) m_fill++;
        end
        for (int i = 0; i < NC; i++)
            m_clr[i] = (m_clr[i] && !(consumed && i == c)) || phase_clr[i];
        if (cfg_we && int'(cfg_ch) < NC) begin
            if (cfg_sel) m_off[cfg_ch] = cfg_data;
            else         m_inc[cfg_ch] = cfg_data;
        end
        exp_valid = (m_fill >= 4);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    exp_t last;
    bit   have_last = 1'b0;

    always @(posedge clk) begin : mon
        bit   e_s;
        bit   r_s;
        exp_t x;
        e_s = clken;
        r_s = reset;
        #1;
        if (r_s) begin
            check("rst_sin",   int'($signed(fsin_o)), 0);
            check("rst_cos",   int'($signed(fcos_o)), 0);
            check("rst_ch",    int'(out_ch), 0);
            check("rst_sop",   int'(out_sop), 0);
            check("rst_valid", int'(out_valid), 0);
            have_last = 1'b0;
        end else begin
            check("out_valid", int'(out_valid), int'(exp_valid));
            if (e_s && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got a sample, expected none at t=%0t", $time);
                end else begin
                    x = exp_q.pop_front();
                    check("sin", int'($signed(fsin_o)), x.s);
                    check("cos", int'($signed(fcos_o)), x.c);
                    check("out_ch", int'(out_ch), x.ch);
                    check("out_sop", int'(out_sop), (x.ch == 0) ? 1 : 0);
                    last      = x;
                    have_last = 1'b1;
                end
            end else if (!e_s && have_last) begin
                check("hold_sin", int'($signed(fsin_o)), last.s);
                check("hold_cos", int'($signed(fcos_o)), last.c);
                check("hold_ch",  int'(out_ch), last.ch);
            end
        end
    end

    // One clock: inputs are already driven (at the falling edge); pulses
    // drop after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cfg_we    = 1'b0;
        phase_clr = '0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            clken = 1'b1;
            cycle();
        end
    endtask

    task automatic wr(input bit sel, input int ch, input logic [APR-1:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_ch   = L2'(ch);
        cfg_data = d;
        clken    = 1'b1;
        cycle();
    endtask

    task automatic run_to_ch(input int ch);
        int guard;
        guard = 0;
        while (m_ch != ch && guard < 2 * NC) begin
            clken = 1'b1;
            cycle();
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1; clken = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_ch = '0; cfg_data = '0; phase_clr = '0;
        repeat (3) cycle();
        reset = 1'b0;

        // All increments zero: every channel at phase 0
        run(20);

        // Quadrant offsets on channels 1..3
        wr(1'b1, 1, 32'h4000_0000);
        wr(1'b1, 2, 32'h8000_0000);
        wr(1'b1, 3, 32'hC000_0000);
        run(16);

        // pi/8 steps on channel 0, past a full phase wrap
        wr(1'b0, 0, 32'h1000_0000);
        run(80);

        // Stall for five cycles, then resume
        clken = 1'b0;
        repeat (5) cycle();
        run(12);

        // Phase clear on ch0, then a second pulse in the consume cycle
        clken = 1'b1;
        phase_clr = 4'b0001;
        cycle();
        run_to_ch(0);
        phase_clr = 4'b0001;
        clken = 1'b1;
        cycle();
        run(16);

        // Increment write to ch2 in the cycle ch2 is visited
        run_to_ch(2);
        wr(1'b0, 2, 32'h0800_0000);
        run(16);

        // Reset mid-stream
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(12);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            clken = ($urandom_range(99) < 80);
            if ($urandom_range(9) == 0) begin
                cfg_we   = 1'b1;
                cfg_sel  = $urandom_range(1);
                cfg_ch   = L2'($urandom_range(NC - 1));
                cfg_data = $urandom;
            end
            if ($urandom_range(7) == 0) phase_clr = NC'($urandom);
            reset = ($urandom_range(599) == 0);
            cycle();
        end
        reset = 1'b0;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
